// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// A single 8-bit ripple adder is time-shared over eight iterations, one per clock.
// A start/done handshake brackets each multiply, and the 16-bit product is held
// in a register until the next multiply completes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// MUL   | one shift-and-add iteration per edge; cnt counts iterations 0..7
// DONE  | product valid for one cycle; start here begins the next multiply

// Combinational 8-bit adder used as the multiplier datapath.
module somador8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);

    // Full 9-bit sum; the carry-out is kept as a separate bit.
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule

module mult8_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  q_q, q_d;
    logic [15:0] product_q, product_d;

    logic [7:0]  addend;
    logic [7:0]  step_sum;
    logic        step_cout;
    logic [15:0] step_res;

    // The multiplicand is added only when the current multiplier LSB is set.
    assign addend = q_q[0] ? m_q : 8'h00;

    somador8bit u_adder (
        .A    (acc_q),
        .B    (addend),
        .Cin  (1'b0),
        .Sum  (step_sum),
        .Cout (step_cout)
    );

    // The 9-bit sum and the multiplier shifted right by one form the new {acc, q}.
    // The carry-out becomes bit 7 of the next acc, so no product bit is lost.
    assign step_res = {step_cout, step_sum, q_q[7:1]};

    // Next-state and datapath update; every register holds its value by default.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = 8'h00;
                    cnt_d   = 3'd0;
                    state_d = ST_MUL;
                end
            end

            ST_MUL: begin
                acc_d = step_res[15:8];
                q_d   = step_res[7:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    product_d = step_res;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = 8'h00;
                    cnt_d   = 3'd0;
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            m_q       <= 8'h00;
            acc_q     <= 8'h00;
            q_q       <= 8'h00;
            product_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            product_q <= product_d;
        end
    end

    // Status outputs decode directly from the registered state.
    assign busy    = (state_q == ST_MUL);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed bench for mult8_seq_ctrl: a table of operand/product vectors plus
// hand-written sequences for start-while-busy, back-to-back, reset abort and
// a strided operand sweep. Every done pulse is compared against exp_prod.
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          tests = 0;
    int          fails = 0;
    int          n_done = 0;
    int          cyc = 0;
    logic [15:0] exp_prod = 16'h0000;
    logic        prev_done = 1'b0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[10];

    mult8_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
        end
    endtask

    // Every done pulse is checked against the product the stimulus expects,
    // and the busy/done handshake is checked for overlap and pulse width.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done === 1'b1) begin
                n_done++;
                check("done_product", product, exp_prod);
            end
            if (busy === 1'b1 && done === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL busy_done_overlap: busy=%b done=%b at cycle %0d", busy, done, cyc);
            end
            if (done === 1'b1 && prev_done === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL done_width: done high two cycles at cycle %0d, expected one", cyc);
            end
        end
        prev_done = done;
    end

    // Waits at negedges until done is seen or the budget expires.
    task automatic wait_done(input int budget);
        int waited;
        waited = 0;
        while (done !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", {15'd0, done}, 16'h0001);
    endtask

    // Full single multiply with latency, busy and one-cycle done checks.
    task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] pv);
        int busy_cnt;
        int guard;
        a        = av;
        b        = bv;
        start    = 1'b1;
        exp_prod = pv;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        guard    = 0;
        while (done !== 1'b1 && guard < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d_busy_cycles", idx), 16'(busy_cnt), 16'd8);
        check($sformatf("v%0d_done", idx), {15'd0, done}, 16'h0001);
        check($sformatf("v%0d_product", idx), product, pv);
        check($sformatf("v%0d_busy_on_done", idx), {15'd0, busy}, 16'h0000);
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", idx), {15'd0, done}, 16'h0000);
        check($sformatf("v%0d_product_held", idx), product, pv);
    endtask

    initial begin
        int n0;
        int c1;
        int c2;
        int c3;

        vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'hA5, 16'h0000};
        vecs[3] = '{8'h80, 8'h02, 16'h0100};
        vecs[4] = '{8'hA5, 8'h00, 16'h0000};
        vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[6] = '{8'hFF, 8'h01, 16'h00FF};
        vecs[7] = '{8'h12, 8'h34, 16'h03A8};
        vecs[8] = '{8'hF0, 8'h0F, 16'h0E10};
        vecs[9] = '{8'h80, 8'h80, 16'h4000};

        // Asynchronous reset between edges takes effect immediately.
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {15'd0, busy}, 16'h0000);
        check("rst_done", {15'd0, done}, 16'h0000);
        check("rst_product", product, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {15'd0, busy}, 16'h0000);

        for (int i = 0; i < 10; i++) begin
            run_op(i, vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Start pulsed again during MUL is ignored; operand changes are not sampled.
        n0       = n_done;
        a        = 8'd3;
        b        = 8'd5;
        exp_prod = 16'h000F;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a     = 8'd7;
        b     = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        check("busy_start_product", product, 16'h000F);
        repeat (15) @(negedge clk);
        check("busy_start_single_done", 16'(n_done - n0), 16'd1);
        check("busy_start_idle", {15'd0, busy}, 16'h0000);

        // Start held high: back-to-back multiplies, one done every 9 cycles.
        n0       = n_done;
        a        = 8'd2;
        b        = 8'd3;
        exp_prod = 16'h0006;
        start    = 1'b1;
        wait_done(20);
        c1 = cyc;
        @(negedge clk);
        wait_done(20);
        c2 = cyc;
        @(negedge clk);
        wait_done(20);
        c3    = cyc;
        start = 1'b0;
        check("b2b_interval1", 16'(c2 - c1), 16'd9);
        check("b2b_interval2", 16'(c3 - c2), 16'd9);
        check("b2b_product", product, 16'h0006);
        @(negedge clk);
        check("b2b_stop_busy", {15'd0, busy}, 16'h0000);
        check("b2b_stop_done", {15'd0, done}, 16'h0000);
        check("b2b_done_count", 16'(n_done - n0), 16'd3);

        // Reset in cycle 4 of a multiply aborts it and clears product.
        n0       = n_done;
        a        = 8'h10;
        b        = 8'h10;
        exp_prod = 16'h0100;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_product", product, 16'h0000);
        check("abort_busy", {15'd0, busy}, 16'h0000);
        check("abort_done", {15'd0, done}, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 16'(n_done - n0), 16'd0);
        check("abort_idle_busy", {15'd0, busy}, 16'h0000);
        check("abort_product_after", product, 16'h0000);

        // Reset released on the same edge that first sees start.
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        a        = 8'h0D;
        b        = 8'h0B;
        exp_prod = 16'h008F;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rel_start_busy", {15'd0, busy}, 16'h0001);
        wait_done(20);
        check("rel_start_product", product, 16'h008F);
        @(negedge clk);

        // Strided sweep of a over all b; the monitor checks each done pulse.
        for (int ai = 0; ai < 256; ai += 17) begin
            for (int bi = 0; bi < 256; bi++) begin
                a        = 8'(ai);
                b        = 8'(bi);
                exp_prod = 16'(ai * bi);
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                wait_done(20);
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
